// File: rtl/prog_loader.sv
// Program loader: parses A5/payload/checksum load packets and 5A exit
// packets from a byte stream, committing accepted requests on frame pulses.
module prog_loader #(
    parameter int PROG_PAYLD_PKT_BITS = 48,
    parameter int TIMEOUT_CYC         = 1000000
) (
    input  logic                           clk_pix,
    input  logic                           rst_pix_n,
    input  logic                           rx_valid,
    input  logic [7:0]                     rx_data,
    input  logic                           frame,
    output logic [PROG_PAYLD_PKT_BITS-1:0] prog_buffer,
    output logic                           is_sym_mode,
    output logic                           pkt_ok,
    output logic                           pkt_err,
    output logic [7:0]                     err_cnt
);

    localparam int N  = PROG_PAYLD_PKT_BITS / 8;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0]    SOP_BYTE  = 8'hA5;
    localparam logic [7:0]    EXIT_BYTE = 8'h5A;
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK
    } state_t;

    state_t                           state;
    logic [IW-1:0]                    idx;
    logic [7:0]                       csum;
    logic [CW-1:0]                    idle_cnt;
    logic [PROG_PAYLD_PKT_BITS-1:0]   shadow;
    logic [PROG_PAYLD_PKT_BITS-1:0]   pend_buf;
    logic                             pend_load;
    logic                             pend_exit;
    logic [7:0]                       err_inc;
    logic                             timed_out;

    assign err_inc   = err_cnt + {7'd0, err_cnt != 8'hFF};
    assign timed_out = (idle_cnt == TO_LAST);

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state       <= IDLE;
            idx         <= '0;
            csum        <= '0;
            idle_cnt    <= '0;
            shadow      <= '0;
            pend_buf    <= '0;
            pend_load   <= 1'b0;
            pend_exit   <= 1'b0;
            prog_buffer <= '0;
            is_sym_mode <= 1'b0;
            pkt_ok      <= 1'b0;
            pkt_err     <= 1'b0;
            err_cnt     <= '0;
        end else begin
            pkt_ok  <= 1'b0;
            pkt_err <= 1'b0;

            // Commit uses the flags as they stood before this edge; an
            // acceptance below overrides the clear and waits for next frame.
            if (frame) begin
                if (pend_load) begin
                    prog_buffer <= pend_buf;
                    is_sym_mode <= 1'b1;
                end else if (pend_exit) begin
                    is_sym_mode <= 1'b0;
                end
                pend_load <= 1'b0;
                pend_exit <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (rx_valid) begin
                        if (rx_data == SOP_BYTE) begin
                            state <= PAYLOAD;
                            idx   <= '0;
                            csum  <= '0;
                        end else if (rx_data == EXIT_BYTE) begin
                            pend_exit <= 1'b1;
                            pend_load <= 1'b0;
                            pkt_ok    <= 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        for (int k = 0; k < N; k++) begin
                            if (idx == IW'(k)) shadow[8*k +: 8] <= rx_data;
                        end
                        csum <= csum ^ rx_data;
                        idx  <= idx + IW'(1);
                        if (idx == LAST_IDX) state <= CHECK;
                    end else if (timed_out) begin
                        state   <= IDLE;
                        pkt_err <= 1'b1;
                        err_cnt <= err_inc;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                CHECK: begin
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        state    <= IDLE;
                        if (rx_data == csum) begin
                            pend_buf  <= shadow;
                            pend_load <= 1'b1;
                            pend_exit <= 1'b0;
                            pkt_ok    <= 1'b1;
                        end else begin
                            pkt_err <= 1'b1;
                            err_cnt <= err_inc;
                        end
                    end else if (timed_out) begin
                        state   <= IDLE;
                        pkt_err <= 1'b1;
                        err_cnt <= err_inc;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected packet verdicts are queued at
// stimulus time and popped when pkt_ok/pkt_err pulses.
module tb_prog_loader;

    localparam int W  = 48;
    localparam int TO = 100;

    logic         clk_pix   = 1'b0;
    logic         rst_pix_n = 1'b0;
    logic         rx_valid  = 1'b0;
    logic [7:0]   rx_data   = 8'h00;
    logic         frame     = 1'b0;
    logic [W-1:0] prog_buffer;
    logic         is_sym_mode;
    logic         pkt_ok;
    logic         pkt_err;
    logic [7:0]   err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];

    prog_loader #(
        .PROG_PAYLD_PKT_BITS(W),
        .TIMEOUT_CYC        (TO)
    ) dut (
        .clk_pix    (clk_pix),
        .rst_pix_n  (rst_pix_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .frame      (frame),
        .prog_buffer(prog_buffer),
        .is_sym_mode(is_sym_mode),
        .pkt_ok     (pkt_ok),
        .pkt_err    (pkt_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk_pix = ~clk_pix;

    // Verdict monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk_pix) begin
        bit e;
        if (rst_pix_n && (pkt_ok || pkt_err)) begin
            n_checks++;
            if (pkt_ok && pkt_err) begin
                n_fail++;
                $display("FAIL pulse_excl: ok=%0b err=%0b, required only one", pkt_ok, pkt_err);
                if (exp_q.size() != 0) e = exp_q.pop_front();
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: ok=%0b err=%0b, required no pulse", pkt_ok, pkt_err);
            end else begin
                e = exp_q.pop_front();
                if (pkt_ok !== e) begin
                    n_fail++;
                    $display("FAIL pkt_verdict: ok=%0b, required ok=%0b", pkt_ok, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic frm);
        @(negedge clk_pix);
        rx_valid = 1'b1;
        rx_data  = b;
        frame    = frm;
        @(negedge clk_pix);
        rx_valid = 1'b0;
        frame    = 1'b0;
    endtask

    task automatic send_pkt(input logic [W-1:0] p, input logic bad, input logic frm_on_csum);
        logic [7:0] c;
        c = 8'h00;
        send_byte(8'hA5, 1'b0);
        for (int k = 0; k < W / 8; k++) begin
            c = c ^ p[8*k +: 8];
            send_byte(p[8*k +: 8], 1'b0);
        end
        exp_q.push_back(!bad);
        send_byte(c ^ {7'd0, bad}, frm_on_csum);
    endtask

    task automatic pulse_frame();
        @(negedge clk_pix);
        frame = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        @(negedge clk_pix);
    endtask

    task automatic drain(input int max_cyc);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < max_cyc) begin
            @(negedge clk_pix);
            #1;
            i++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d verdicts outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_pix);
        n_checks++;
        if (prog_buffer !== '0) begin
            n_fail++;
            $display("FAIL reset_buf: got %h, required 0", prog_buffer);
        end
        n_checks++;
        if (is_sym_mode !== 1'b0 || pkt_ok !== 1'b0 || pkt_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: sym=%b ok=%b err=%b, required 0", is_sym_mode, pkt_ok, pkt_err);
        end
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_errcnt: got %0d, required 0", err_cnt);
        end
        rst_pix_n = 1'b1;
        repeat (2) @(negedge clk_pix);
    endtask

    task automatic test_load();
        logic [W-1:0] p;
        p = 48'h0A0F00200010;
        send_byte(8'hA5, 1'b0);
        for (int k = 0; k < 6; k++) send_byte(p[8*k +: 8], 1'b0);
        exp_q.push_back(1'b1);
        send_byte(8'h35, 1'b0);
        drain(5);
        n_checks++;
        if (is_sym_mode !== 1'b0 || prog_buffer !== '0) begin
            n_fail++;
            $display("FAIL load_precommit: buf=%h sym=%b, required 0/0", prog_buffer, is_sym_mode);
        end
        pulse_frame();
        n_checks++;
        if (prog_buffer !== p || is_sym_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL load_commit: buf=%h sym=%b, required %h/1", prog_buffer, is_sym_mode, p);
        end
    endtask

    task automatic test_bad_csum();
        send_pkt(48'h0A0F00200010, 1'b1, 1'b0);
        drain(5);
        n_checks++;
        if (err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL bad_errcnt: got %0d, required 1", err_cnt);
        end
        pulse_frame();
        n_checks++;
        if (prog_buffer !== 48'h0A0F00200010 || is_sym_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_nochange: buf=%h sym=%b, required 0a0f00200010/1", prog_buffer, is_sym_mode);
        end
    endtask

    task automatic test_timeout();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        exp_q.push_back(1'b0);
        send_byte(8'h22, 1'b0);
        repeat (TO - 5) @(negedge clk_pix);
        #1;
        n_checks++;
        if (exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL timeout_early: outstanding=%0d, required 1", exp_q.size());
        end
        drain(20);
        n_checks++;
        if (err_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL timeout_errcnt: got %0d, required 2", err_cnt);
        end
        send_pkt(48'h665544332211, 1'b0, 1'b0);
        drain(5);
        pulse_frame();
        n_checks++;
        if (prog_buffer !== 48'h665544332211) begin
            n_fail++;
            $display("FAIL timeout_recover: got %h, required 665544332211", prog_buffer);
        end
    endtask

    task automatic test_back_to_back();
        send_pkt(48'hDEADBEEF0001, 1'b0, 1'b0);
        send_pkt(48'hCAFEF00D0002, 1'b0, 1'b0);
        drain(5);
        pulse_frame();
        n_checks++;
        if (prog_buffer !== 48'hCAFEF00D0002) begin
            n_fail++;
            $display("FAIL latest_wins: got %h, required cafef00d0002", prog_buffer);
        end
        send_pkt(48'h123456789ABC, 1'b0, 1'b1);
        drain(5);
        n_checks++;
        if (prog_buffer !== 48'hCAFEF00D0002) begin
            n_fail++;
            $display("FAIL same_cycle_frame: got %h, required cafef00d0002", prog_buffer);
        end
        pulse_frame();
        n_checks++;
        if (prog_buffer !== 48'h123456789ABC) begin
            n_fail++;
            $display("FAIL deferred_commit: got %h, required 123456789abc", prog_buffer);
        end
    endtask

    task automatic test_marker_data();
        send_pkt(48'h5AA55AA5A55A, 1'b0, 1'b0);
        drain(5);
        pulse_frame();
        n_checks++;
        if (prog_buffer !== 48'h5AA55AA5A55A) begin
            n_fail++;
            $display("FAIL marker_as_data: got %h, required 5aa55aa5a55a", prog_buffer);
        end
    endtask

    task automatic test_exit();
        send_byte(8'h33, 1'b0);
        repeat (3) @(negedge clk_pix);
        n_checks++;
        if (err_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL ignored_byte: err_cnt=%0d, required 2", err_cnt);
        end
        exp_q.push_back(1'b1);
        send_byte(8'h5A, 1'b0);
        drain(5);
        n_checks++;
        if (is_sym_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL exit_precommit: sym=%b, required 1", is_sym_mode);
        end
        pulse_frame();
        n_checks++;
        if (is_sym_mode !== 1'b0 || prog_buffer !== 48'h5AA55AA5A55A) begin
            n_fail++;
            $display("FAIL exit_commit: sym=%b buf=%h, required 0/5aa55aa5a55a", is_sym_mode, prog_buffer);
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        #2;
        rst_pix_n = 1'b0;
        #1;
        n_checks++;
        if (prog_buffer !== '0 || is_sym_mode !== 1'b0 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid: buf=%h sym=%b err_cnt=%0d, required 0/0/0", prog_buffer, is_sym_mode, err_cnt);
        end
        repeat (2) @(negedge clk_pix);
        rst_pix_n = 1'b1;
        send_pkt(48'hA1B2C3D4E5F6, 1'b0, 1'b0);
        drain(5);
        pulse_frame();
        n_checks++;
        if (prog_buffer !== 48'hA1B2C3D4E5F6 || is_sym_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_reload: buf=%h sym=%b, required a1b2c3d4e5f6/1", prog_buffer, is_sym_mode);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 254; i++) send_pkt(48'($urandom), 1'b1, 1'b0);
        drain(5);
        n_checks++;
        if (err_cnt !== 8'd254) begin
            n_fail++;
            $display("FAIL sat_254: got %0d, required 254", err_cnt);
        end
        for (int i = 0; i < 46; i++) send_pkt(48'($urandom), 1'b1, 1'b0);
        drain(5);
        n_checks++;
        if (err_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_255: got %0d, required 255", err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_bad_csum();
        test_timeout();
        test_back_to_back();
        test_marker_data();
        test_exit();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
